axi_stream_rr_arbiter: RTL and testbench

Round-robin N-to-1 AXI4-Stream packet arbiter. Merges NUM_SOURCES slave streams onto one master stream and locks the grant for a whole packet, from the first beat to the beat with tlast. The output is a registered one-beat slice. m_tid carries the granted source index so downstream logic can demultiplex. It sits ahead of a shared stream consumer (DMA or width converter), and both sides are checked by the stream protocol monitors.

---
 rtl/axi_stream_rr_arbiter.sv | 170 +++++++++++++++++
 tb/tb_axi_stream_rr_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_rr_arbiter.sv
// Purpose: round-robin N-to-1 AXI4-Stream packet arbiter with the grant locked from first beat to tlast.
// Latency: request -> s_tready one cycle later -> m_tvalid one cycle after that; one idle bubble between packets.
// Backpressure: only the granted source sees tready, combinationally from m_tready; the output slice holds while stalled.
module axi_stream_rr_arbiter #(
    parameter int NUM_SOURCES = 4,
    parameter int byte_width  = 4,
    parameter int id_width    = 2
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic [NUM_SOURCES-1:0]                s_tvalid,
    output logic [NUM_SOURCES-1:0]                s_tready,
    input  logic [NUM_SOURCES*8*byte_width-1:0]   s_tdata,
    input  logic [NUM_SOURCES*byte_width-1:0]     s_tkeep,
    input  logic [NUM_SOURCES*byte_width-1:0]     s_tstrb,
    input  logic [NUM_SOURCES-1:0]                s_tlast,
    output logic                                  m_tvalid,
    input  logic                                  m_tready,
    output logic [8*byte_width-1:0]               m_tdata,
    output logic [byte_width-1:0]                 m_tkeep,
    output logic [byte_width-1:0]                 m_tstrb,
    output logic                                  m_tlast,
    output logic [id_width-1:0]                   m_tid,
    output logic                                  busy
);

    localparam int DW = 8 * byte_width;
    localparam int KW = byte_width;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]          state_q,      state_d;
    logic [id_width-1:0] grant_q,      grant_d;
    logic [id_width-1:0] last_grant_q, last_grant_d;
    logic                m_tvalid_q,   m_tvalid_d;
    logic [DW-1:0]       m_tdata_q,    m_tdata_d;
    logic [KW-1:0]       m_tkeep_q,    m_tkeep_d;
    logic [KW-1:0]       m_tstrb_q,    m_tstrb_d;
    logic                m_tlast_q,    m_tlast_d;
    logic [id_width-1:0] m_tid_q,      m_tid_d;

    logic                sel_tvalid;
    logic [DW-1:0]       sel_tdata;
    logic [KW-1:0]       sel_tkeep;
    logic [KW-1:0]       sel_tstrb;
    logic                sel_tlast;
    logic                slot_free;
    logic                accept;
    logic                pick_vld;
    logic [id_width-1:0] pick_idx;

    // The output slice can take a new beat when empty or draining this cycle.
    assign slot_free = !m_tvalid_q || m_tready;
    assign accept    = (state_q == ST_LOCKED) && sel_tvalid && slot_free;

    // Route the granted source's slice to the output slice inputs.
    always_comb begin
        sel_tvalid = 1'b0;
        sel_tdata  = '0;
        sel_tkeep  = '0;
        sel_tstrb  = '0;
        sel_tlast  = 1'b0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (grant_q == id_width'(i)) begin
                sel_tvalid = s_tvalid[i];
                sel_tdata  = s_tdata[i*DW +: DW];
                sel_tkeep  = s_tkeep[i*KW +: KW];
                sel_tstrb  = s_tstrb[i*KW +: KW];
                sel_tlast  = s_tlast[i];
            end
        end
    end

    // Round-robin pick: lowest requester above last_grant wins, else lowest requester at or below it.
    always_comb begin
        pick_vld = |s_tvalid;
        pick_idx = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (s_tvalid[i] && (id_width'(i) <= last_grant_q)) begin
                pick_idx = id_width'(i);
            end
        end
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (s_tvalid[i] && (id_width'(i) > last_grant_q)) begin
                pick_idx = id_width'(i);
            end
        end
    end

    // Only the locked source ever sees tready, and only when the slice can take a beat.
    always_comb begin
        s_tready = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            s_tready[i] = (state_q == ST_LOCKED) && (grant_q == id_width'(i)) && slot_free;
        end
    end

    // Arbitrate in IDLE, hold the grant in LOCKED until the tlast beat is accepted.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        if (state_q == ST_IDLE) begin
            if (pick_vld) begin
                grant_d = pick_idx;
                state_d = ST_LOCKED;
            end
        end else begin
            if (accept && sel_tlast) begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
        end
    end

    // One-beat output slice: load on accept, otherwise drop valid once the beat is taken.
    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tstrb_d  = m_tstrb_q;
        m_tlast_d  = m_tlast_q;
        m_tid_d    = m_tid_q;
        if (accept) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = sel_tdata;
            m_tkeep_d  = sel_tkeep;
            m_tstrb_d  = sel_tstrb;
            m_tlast_d  = sel_tlast;
            m_tid_d    = grant_q;
        end else if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    // State registers; reset drops any packet in flight and any buffered beat.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= id_width'(NUM_SOURCES - 1);
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            m_tkeep_q    <= '0;
            m_tstrb_q    <= '0;
            m_tlast_q    <= 1'b0;
            m_tid_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            m_tkeep_q    <= m_tkeep_d;
            m_tstrb_q    <= m_tstrb_d;
            m_tlast_q    <= m_tlast_d;
            m_tid_q      <= m_tid_d;
        end
    end

    assign m_tvalid = m_tvalid_q;
    assign m_tdata  = m_tdata_q;
    assign m_tkeep  = m_tkeep_q;
    assign m_tstrb  = m_tstrb_q;
    assign m_tlast  = m_tlast_q;
    assign m_tid    = m_tid_q;
    assign busy     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Purpose: scoreboard bench for axi_stream_rr_arbiter covering reset, fairness, packet lock, stalls, mid-packet reset, idle skipping.
// Latency: expects request -> tready one cycle later -> output beat the cycle after.
// Backpressure: m_tready is driven per cycle by each scenario.
module tb_axi_stream_rr_arbiter;

    localparam int NS = 4;
    localparam int BW = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [BW-1:0] keep;
        logic [BW-1:0] strb;
        logic          last;
        logic [IW-1:0] id;
    } beat_t;

    logic             clk;
    logic             resetn;
    logic [NS-1:0]    s_tvalid;
    logic [NS-1:0]    s_tready;
    logic [NS*DW-1:0] s_tdata;
    logic [NS*BW-1:0] s_tkeep;
    logic [NS*BW-1:0] s_tstrb;
    logic [NS-1:0]    s_tlast;
    logic             m_tvalid;
    logic             m_tready;
    logic [DW-1:0]    m_tdata;
    logic [BW-1:0]    m_tkeep;
    logic [BW-1:0]    m_tstrb;
    logic             m_tlast;
    logic [IW-1:0]    m_tid;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    beat_t src_mem [NS][16];
    int    src_rd    [NS];
    int    src_wr    [NS];
    int    src_start [NS];
    beat_t exp_q [$];

    logic          mready_drv;
    logic          o_fire;
    logic          o_mvalid;
    logic          o_busy;
    logic [NS-1:0] o_s_tready;
    beat_t         o_beat;

    axi_stream_rr_arbiter #(
        .NUM_SOURCES (NS),
        .byte_width  (BW),
        .id_width    (IW)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tstrb  (s_tstrb),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tstrb  (m_tstrb),
        .m_tlast  (m_tlast),
        .m_tid    (m_tid),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic clear_sources();
        for (int i = 0; i < NS; i++) begin
            src_rd[i]    = 0;
            src_wr[i]    = 0;
            src_start[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic push_src(input int s, input logic [DW-1:0] d, input logic last, output beat_t b);
        b.data = d;
        b.keep = d[3:0] ^ 4'h5;
        b.strb = ~d[7:4];
        b.last = last;
        b.id   = s[IW-1:0];
        src_mem[s][src_wr[s]] = b;
        src_wr[s] = src_wr[s] + 1;
    endtask

    // One clock: drive sources and m_tready after the falling edge, sample just after, then take the rising edge.
    task automatic cycle();
        logic [NS-1:0] fire;
        beat_t b;
        for (int i = 0; i < NS; i++) begin
            if (src_rd[i] < src_wr[i] && cyc >= src_start[i]) begin
                b = src_mem[i][src_rd[i]];
                s_tvalid[i]          = 1'b1;
                s_tdata[i*DW +: DW]  = b.data;
                s_tkeep[i*BW +: BW]  = b.keep;
                s_tstrb[i*BW +: BW]  = b.strb;
                s_tlast[i]           = b.last;
            end else begin
                s_tvalid[i]          = 1'b0;
                s_tdata[i*DW +: DW]  = '0;
                s_tkeep[i*BW +: BW]  = '0;
                s_tstrb[i*BW +: BW]  = '0;
                s_tlast[i]           = 1'b0;
            end
        end
        m_tready = mready_drv;
        #1;
        o_mvalid    = m_tvalid;
        o_fire      = m_tvalid && m_tready;
        o_busy      = busy;
        o_s_tready  = s_tready;
        o_beat.data = m_tdata;
        o_beat.keep = m_tkeep;
        o_beat.strb = m_tstrb;
        o_beat.last = m_tlast;
        o_beat.id   = m_tid;
        fire        = s_tvalid & s_tready;
        @(posedge clk);
        for (int i = 0; i < NS; i++) begin
            if (fire[i]) src_rd[i] = src_rd[i] + 1;
        end
        cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        resetn     = 1'b0;
        mready_drv = 1'b1;
        clear_sources();
        cycle();
        cycle();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        beat_t b, e;
        int rel, budget, n;
        resetn     = 1'b0;
        mready_drv = 1'b1;
        clear_sources();
        for (int s = 0; s < NS; s++) begin
            push_src(s, 32'h5EED_0000 + 32'(s), 1'b1, b);
            exp_q.push_back(b);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (o_mvalid !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid got=%b exp=0", o_mvalid); end
            checks++;
            if (o_s_tready !== 4'b0000) begin failures++; $display("FAIL reset_s_tready got=%b exp=0000", o_s_tready); end
            checks++;
            if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
            checks++;
            if (o_beat !== beat_t'(0)) begin failures++; $display("FAIL reset_m_regs got=%h exp=0", o_beat); end
        end
        resetn = 1'b1;
        rel = 0; budget = 40; n = 0;
        while (exp_q.size() > 0 && budget > 0) begin
            cycle();
            rel++; budget--;
            if (rel == 2) begin
                checks++;
                if (o_s_tready !== 4'b0001) begin failures++; $display("FAIL reset_first_tready got=%b exp=0001", o_s_tready); end
            end
            if (o_fire) begin
                e = exp_q.pop_front();
                checks++;
                if (o_beat !== e) begin failures++; $display("FAIL reset_beat%0d got=%h exp=%h", n, o_beat, e); end
                if (n == 0) begin
                    checks++;
                    if (rel != 3) begin failures++; $display("FAIL reset_first_latency got=%0d exp=3", rel); end
                end
                n++;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL reset_timeout pending=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_fairness();
        beat_t b, e;
        int budget, n, prev;
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < NS; s++) begin
                push_src(s, 32'h1000_0000 + 32'(r * 16 + s), 1'b1, b);
                exp_q.push_back(b);
            end
        end
        for (int s = 0; s < NS; s++) src_start[s] = cyc;
        budget = 100; n = 0; prev = 0;
        while (exp_q.size() > 0 && budget > 0) begin
            cycle();
            budget--;
            if (o_fire) begin
                e = exp_q.pop_front();
                checks++;
                if (o_beat !== e) begin failures++; $display("FAIL fairness_beat%0d got=%h exp=%h", n, o_beat, e); end
                if (n > 0) begin
                    checks++;
                    if (cyc - prev != 2) begin failures++; $display("FAIL fairness_gap%0d got=%0d exp=2", n, cyc - prev); end
                end
                prev = cyc;
                n++;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL fairness_timeout pending=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_packet_lock();
        beat_t b, e;
        int budget, n, prev, gap;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            push_src(2, 32'h0000_00A0 + 32'(k), (k == 4), b);
            exp_q.push_back(b);
        end
        push_src(1, 32'h0000_00B1, 1'b1, b);
        exp_q.push_back(b);
        src_start[2] = cyc;
        src_start[1] = cyc + 2;
        budget = 60; n = 0; prev = 0;
        while (exp_q.size() > 0 && budget > 0) begin
            cycle();
            budget--;
            if (o_fire) begin
                e = exp_q.pop_front();
                checks++;
                if (o_beat !== e) begin failures++; $display("FAIL lock_beat%0d got=%h exp=%h", n, o_beat, e); end
                checks++;
                if (o_busy !== !e.last) begin failures++; $display("FAIL lock_busy%0d got=%b exp=%b", n, o_busy, !e.last); end
                if (n > 0) begin
                    gap = (n == 5) ? 2 : 1;
                    checks++;
                    if (cyc - prev != gap) begin failures++; $display("FAIL lock_gap%0d got=%0d exp=%0d", n, cyc - prev, gap); end
                end
                prev = cyc;
                n++;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL lock_timeout pending=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        beat_t b, e;
        int budget, n, prev, stall_left, gap;
        logic stalled;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            push_src(0, 32'hC0C0_00C0 + 32'(k), (k == 5), b);
            exp_q.push_back(b);
        end
        src_start[0] = cyc;
        budget = 60; n = 0; prev = 0; stall_left = 0; stalled = 1'b0;
        while (exp_q.size() > 0 && budget > 0) begin
            mready_drv = (stall_left == 0);
            cycle();
            budget--;
            if (!mready_drv) begin
                stall_left--;
                checks++;
                if (o_mvalid !== 1'b1) begin failures++; $display("FAIL stall_m_tvalid got=%b exp=1", o_mvalid); end
                checks++;
                if (o_beat !== exp_q[0]) begin failures++; $display("FAIL stall_hold got=%h exp=%h", o_beat, exp_q[0]); end
                checks++;
                if (o_s_tready !== 4'b0000) begin failures++; $display("FAIL stall_s_tready got=%b exp=0000", o_s_tready); end
            end
            if (o_fire) begin
                e = exp_q.pop_front();
                checks++;
                if (o_beat !== e) begin failures++; $display("FAIL bp_beat%0d got=%h exp=%h", n, o_beat, e); end
                if (n > 0) begin
                    gap = (n == 2) ? 4 : 1;
                    checks++;
                    if (cyc - prev != gap) begin failures++; $display("FAIL bp_gap%0d got=%0d exp=%0d", n, cyc - prev, gap); end
                end
                prev = cyc;
                n++;
                if (n == 2 && !stalled) begin
                    stall_left = 3;
                    stalled    = 1'b1;
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL bp_timeout pending=%0d exp=0", exp_q.size()); end
        mready_drv = 1'b1;
        cycle();
        checks++;
        if (o_mvalid !== 1'b0 || o_busy !== 1'b0) begin
            failures++; $display("FAIL bp_drained got valid=%b busy=%b exp valid=0 busy=0", o_mvalid, o_busy);
        end
    endtask

    task automatic test_reset_mid_packet();
        beat_t b, e;
        int budget, n, rel;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            push_src(0, 32'hD00D_00D0 + 32'(k), (k == 3), b);
            if (k < 2) exp_q.push_back(b);
        end
        src_start[0] = cyc;
        budget = 40; n = 0;
        while (n < 2 && budget > 0) begin
            cycle();
            budget--;
            if (o_fire) begin
                e = exp_q.pop_front();
                checks++;
                if (o_beat !== e) begin failures++; $display("FAIL midrst_beat%0d got=%h exp=%h", n, o_beat, e); end
                n++;
            end
        end
        checks++;
        if (n != 2) begin failures++; $display("FAIL midrst_timeout beats=%0d exp=2", n); end
        resetn = 1'b0;
        clear_sources();
        cycle();
        resetn = 1'b1;
        cycle();
        checks++;
        if (o_mvalid !== 1'b0) begin failures++; $display("FAIL midrst_m_tvalid got=%b exp=0", o_mvalid); end
        checks++;
        if (o_busy !== 1'b0 || o_s_tready !== 4'b0000) begin
            failures++; $display("FAIL midrst_state got busy=%b tready=%b exp busy=0 tready=0000", o_busy, o_s_tready);
        end
        checks++;
        if (o_beat !== beat_t'(0)) begin failures++; $display("FAIL midrst_m_regs got=%h exp=0", o_beat); end
        push_src(3, 32'hE3E3_00E3, 1'b1, b);
        exp_q.push_back(b);
        src_start[3] = cyc;
        budget = 20; rel = 0;
        while (exp_q.size() > 0 && budget > 0) begin
            cycle();
            budget--; rel++;
            if (o_fire) begin
                e = exp_q.pop_front();
                checks++;
                if (o_beat !== e) begin failures++; $display("FAIL midrst_new_beat got=%h exp=%h", o_beat, e); end
                checks++;
                if (rel != 3) begin failures++; $display("FAIL midrst_latency got=%0d exp=3", rel); end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL midrst_new_timeout pending=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_skip_idle();
        beat_t b, e;
        int budget, n;
        apply_reset();
        push_src(1, 32'hF1F1_00F1, 1'b1, b);
        exp_q.push_back(b);
        src_start[1] = cyc;
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            cycle();
            budget--;
            if (o_fire) begin
                e = exp_q.pop_front();
                checks++;
                if (o_beat !== e) begin failures++; $display("FAIL skip_prime got=%h exp=%h", o_beat, e); end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL skip_prime_timeout pending=%0d exp=0", exp_q.size()); end
        for (int r = 0; r < 2; r++) begin
            push_src(3, 32'h3300_0000 + 32'(r), 1'b1, b);
            exp_q.push_back(b);
            push_src(1, 32'h1100_0000 + 32'(r), 1'b1, b);
            exp_q.push_back(b);
        end
        src_start[1] = cyc;
        src_start[3] = cyc;
        budget = 40; n = 0;
        while (exp_q.size() > 0 && budget > 0) begin
            cycle();
            budget--;
            if (o_fire) begin
                e = exp_q.pop_front();
                checks++;
                if (o_beat !== e) begin failures++; $display("FAIL skip_beat%0d got=%h exp=%h", n, o_beat, e); end
                n++;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL skip_timeout pending=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        resetn     = 1'b0;
        mready_drv = 1'b1;
        m_tready   = 1'b1;
        s_tvalid   = '0;
        s_tdata    = '0;
        s_tkeep    = '0;
        s_tstrb    = '0;
        s_tlast    = '0;
        clear_sources();
        @(negedge clk);
        test_reset();
        test_fairness();
        test_packet_lock();
        test_backpressure();
        test_reset_mid_packet();
        test_skip_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
